estufa_ctrl: RTL and testbench



---
 rtl/estufa_ctrl.sv | 147 ++++++++++++++
 tb/tb_estufa_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/estufa_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : estufa_ctrl
// Brief    : Greenhouse heater/cooler sequencer: sensor glitch filters, Moore
//            FSM with min-on time, dead-time and latched fault alarm.
//            Optional RUNTIME_CNT_EN adds the run_cycles actuator-on counter.
// Revision : 1.0 - initial release
// =============================================================================
module estufa_ctrl #(
    parameter int FILT_CYCLES   = 2,
    parameter int MIN_ON_CYCLES = 8,
    parameter int DEAD_CYCLES   = 4
) (
    input  logic        clk_2,
    input  logic        reset,
    input  logic        enable,
    input  logic        sens_hot,
    input  logic        sens_cold,
    input  logic        clear_fault,
    output logic        heater,
    output logic        cooler,
    output logic        alarm,
`ifdef RUNTIME_CNT_EN
    output logic [15:0] run_cycles,
`endif
    output logic [2:0]  state_dbg
);

    localparam int FW = (FILT_CYCLES   > 1) ? $clog2(FILT_CYCLES)   : 1;
    localparam int OW = (MIN_ON_CYCLES > 1) ? $clog2(MIN_ON_CYCLES) : 1;
    localparam int DW = (DEAD_CYCLES   > 1) ? $clog2(DEAD_CYCLES)   : 1;

    localparam logic [FW-1:0] C_FILT_MAX = FW'(FILT_CYCLES - 1);
    localparam logic [OW-1:0] C_ON_MAX   = OW'(MIN_ON_CYCLES - 1);
    localparam logic [DW-1:0] C_DEAD_MAX = DW'(DEAD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HEAT  = 3'd1,
        COOL  = 3'd2,
        DEAD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   on_cnt_q, on_cnt_d;
    logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
    logic [1:0]      sens_raw;
    logic [1:0]      sens_filt;
    logic            f_hot, f_cold, fault_cond, demand;

    // Bit 1 carries the hot sensor, bit 0 the cold sensor.
    assign sens_raw = {sens_hot, sens_cold};

    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic          filt_q;
        logic [FW-1:0] cnt_q;

        always_ff @(posedge clk_2) begin
            if (reset) begin
                filt_q <= 1'b0;
                cnt_q  <= '0;
            end else if (sens_raw[i] == filt_q) begin
                cnt_q  <= '0;
            end else if (cnt_q == C_FILT_MAX) begin
                filt_q <= sens_raw[i];
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end

        assign sens_filt[i] = filt_q;
    end

    assign f_hot      = sens_filt[1];
    assign f_cold     = sens_filt[0];
    assign fault_cond = f_hot & f_cold;
    // The condition that keeps the active actuator wanted.
    assign demand     = (state_q == HEAT) ? f_cold : f_hot;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q    <= IDLE;
            on_cnt_q   <= '0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            on_cnt_q   <= on_cnt_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        on_cnt_d   = on_cnt_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            IDLE: begin
                if (fault_cond)           state_d = FAULT;
                else if (enable & f_cold) state_d = HEAT;
                else if (enable & f_hot)  state_d = COOL;
            end
            HEAT, COOL: begin
                if (fault_cond)                             state_d = FAULT;
                else if (!enable)                           state_d = DEAD;
                else if ((on_cnt_q == C_ON_MAX) && !demand) state_d = DEAD;
                else if (on_cnt_q != C_ON_MAX)              on_cnt_d = on_cnt_q + 1'b1;
            end
            DEAD: begin
                if (fault_cond)                    state_d = FAULT;
                else if (dead_cnt_q == C_DEAD_MAX) state_d = IDLE;
                else                               dead_cnt_d = dead_cnt_q + 1'b1;
            end
            FAULT: begin
                if (clear_fault & !fault_cond) state_d = DEAD;
            end
            default: state_d = IDLE;
        endcase
        // Every state entry starts its timers from zero.
        if (state_d != state_q) begin
            on_cnt_d   = '0;
            dead_cnt_d = '0;
        end
    end

    assign heater    = (state_q == HEAT);
    assign cooler    = (state_q == COOL);
    assign alarm     = (state_q == FAULT);
    assign state_dbg = state_q;

`ifdef RUNTIME_CNT_EN
    logic [15:0] run_q;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            run_q <= '0;
        end else if ((heater | cooler) && (run_q != 16'hFFFF)) begin
            run_q <= run_q + 16'd1;
        end
    end

    assign run_cycles = run_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_estufa_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_estufa_ctrl
// Brief    : Directed scenarios plus randomized stimulus for estufa_ctrl,
//            checked each cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_estufa_ctrl;

    localparam int FILT   = 2;
    localparam int MIN_ON = 8;
    localparam int DEAD   = 4;
    localparam int S_IDLE = 0, S_HEAT = 1, S_COOL = 2, S_DEAD = 3, S_FAULT = 4;

    logic       clk_2 = 1'b0;
    logic       reset, enable, sens_hot, sens_cold, clear_fault;
    logic       heater, cooler, alarm;
    logic [2:0] state_dbg;
`ifdef RUNTIME_CNT_EN
    logic [15:0] run_cycles;
`endif

    estufa_ctrl #(
        .FILT_CYCLES   (FILT),
        .MIN_ON_CYCLES (MIN_ON),
        .DEAD_CYCLES   (DEAD)
    ) u_dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .enable      (enable),
        .sens_hot    (sens_hot),
        .sens_cold   (sens_cold),
        .clear_fault (clear_fault),
        .heater      (heater),
        .cooler      (cooler),
        .alarm       (alarm),
`ifdef RUNTIME_CNT_EN
        .run_cycles  (run_cycles),
`endif
        .state_dbg   (state_dbg)
    );

    always #5 clk_2 = ~clk_2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: filtered levels, a run length of disagreeing samples,
    // the mode and how many edges it has been held.
    int m_fh, m_fc, m_runh, m_runc, m_st, m_age, m_run;

    task automatic model_step();
        int nst, fault, want;
        if (reset) begin
            m_fh = 0; m_fc = 0; m_runh = 0; m_runc = 0;
            m_st = S_IDLE; m_age = 0; m_run = 0;
            return;
        end
        fault = m_fh & m_fc;
        nst   = m_st;
        case (m_st)
            S_IDLE: begin
                if (fault != 0)               nst = S_FAULT;
                else if (enable && m_fc != 0) nst = S_HEAT;
                else if (enable && m_fh != 0) nst = S_COOL;
            end
            S_HEAT, S_COOL: begin
                want = (m_st == S_HEAT) ? m_fc : m_fh;
                if (fault != 0)                            nst = S_FAULT;
                else if (!enable)                          nst = S_DEAD;
                else if (m_age >= MIN_ON - 1 && want == 0) nst = S_DEAD;
            end
            S_DEAD: begin
                if (fault != 0)             nst = S_FAULT;
                else if (m_age >= DEAD - 1) nst = S_IDLE;
            end
            default: begin
                if (clear_fault && fault == 0) nst = S_DEAD;
            end
        endcase
        if ((m_st == S_HEAT || m_st == S_COOL) && m_run < 65535) m_run++;
        m_age = (nst == m_st) ? m_age + 1 : 0;
        m_st  = nst;
        if (int'(sens_hot) != m_fh) begin
            m_runh++;
            if (m_runh >= FILT) begin m_fh = int'(sens_hot); m_runh = 0; end
        end else m_runh = 0;
        if (int'(sens_cold) != m_fc) begin
            m_runc++;
            if (m_runc >= FILT) begin m_fc = int'(sens_cold); m_runc = 0; end
        end else m_runc = 0;
    endtask

    // Observed-output bookkeeping for the safety guarantees.
    int cyc = 0;
    int h_fall = -1000, c_fall = -1000, h_len = 0, c_len = 0;
    logic p_heat = 1'b0, p_cool = 1'b0;

    task automatic tick();
        logic en_at, rst_at;
        en_at  = enable;
        rst_at = reset;
        @(posedge clk_2);
        model_step();
        #1;
        cyc++;
        check("state", int'(state_dbg), m_st);
        check("heater", int'(heater), int'(m_st == S_HEAT));
        check("cooler", int'(cooler), int'(m_st == S_COOL));
        check("alarm", int'(alarm), int'(m_st == S_FAULT));
        check("exclusive", int'(heater & cooler), 0);
`ifdef RUNTIME_CNT_EN
        check("run_cycles", int'(run_cycles), m_run);
`endif
        if (heater && !p_heat && cyc - c_fall < DEAD + 1)
            check("gap_c2h", cyc - c_fall, DEAD + 1);
        if (cooler && !p_cool && cyc - h_fall < DEAD + 1)
            check("gap_h2c", cyc - h_fall, DEAD + 1);
        if (!heater && p_heat) begin
            h_fall = cyc;
            check("min_on_heat", int'(h_len >= MIN_ON || alarm || !en_at || rst_at), 1);
        end
        if (!cooler && p_cool) begin
            c_fall = cyc;
            check("min_on_cool", int'(c_len >= MIN_ON || alarm || !en_at || rst_at), 1);
        end
        if (rst_at) begin h_fall = -1000; c_fall = -1000; end
        h_len  = heater ? h_len + 1 : 0;
        c_len  = cooler ? c_len + 1 : 0;
        p_heat = heater;
        p_cool = cooler;
    endtask

    initial begin
        int exp_st;
        reset = 1'b1; enable = 1'b0; sens_hot = 1'b0; sens_cold = 1'b0; clear_fault = 1'b0;
        tick(); tick();
        check("rst_state", int'(state_dbg), 0);
        check("rst_outs", int'({heater, cooler, alarm}), 0);

        // Heating start, min-on, dead-time, then hand-over to cooling.
        reset = 1'b0; sens_cold = 1'b1; enable = 1'b1;
        tick(); tick();
        check("filter_latency", int'(heater), 0);
        tick();
        check("heat_on", int'(state_dbg), 1);
        for (int k = 4; k <= 16; k++) begin
            if (k == 4) begin sens_cold = 1'b0; sens_hot = 1'b1; end
            tick();
            exp_st = (k <= 10) ? 1 : (k <= 14) ? 3 : (k == 15) ? 0 : 2;
            check("handover_seq", int'(state_dbg), exp_st);
        end

        // Contradictory sensors during cooling.
        sens_cold = 1'b1;
        tick(); tick(); tick();
        check("fault_state", int'(state_dbg), 4);
        check("fault_outs", int'({heater, cooler, alarm}), 1);
        clear_fault = 1'b1;
        tick(); tick();
        check("clear_ignored", int'(state_dbg), 4);
        clear_fault = 1'b0; sens_cold = 1'b0;
        tick(); tick();
        clear_fault = 1'b1;
        tick();
        check("fault_to_dead", int'(state_dbg), 3);
        clear_fault = 1'b0; enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("dead_hold", int'(state_dbg), 3);
        end
        tick();
        check("dead_to_idle", int'(state_dbg), 0);

        // Single-cycle glitch while idle.
        sens_hot = 1'b0;
        tick(); tick(); tick();
        enable = 1'b1;
        tick();
        sens_hot = 1'b1;
        tick();
        sens_hot = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("glitch_idle", int'(state_dbg), 0);
        end

        // Enable dropped early in heating overrides min-on.
        sens_cold = 1'b1;
        tick(); tick(); tick();
        check("heat_again", int'(heater), 1);
        tick(); tick();
        enable = 1'b0;
        tick();
        check("enable_drop", int'(state_dbg), 3);
        enable = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check("reheat", int'(heater), 1);

        // Reset while heating: immediate drop, filters restart.
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_heat", int'({heater, state_dbg}), 0);
        end
        reset = 1'b0;
        tick(); tick();
        check("rst_refilter", int'(heater), 0);
        tick();
        check("rst_reheat", int'(heater), 1);

        // Randomized soak.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0) sens_hot  = ~sens_hot;
            if ($urandom_range(0, 7) == 0) sens_cold = ~sens_cold;
            enable      = ($urandom_range(0, 15) != 0);
            clear_fault = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
